// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, 16-entry
// branch-target table, and a saturating RUN-cycle counter for benchmarking.
module pc_fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             branch_i,
  input  logic [3:0]       br_idx_i,
  input  logic             lut_we_i,
  input  logic [3:0]       lut_addr_i,
  input  logic [PC_W-1:0]  lut_data_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             run_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam int            NUM_ENT  = 16;
  localparam logic [PC_W-1:0]  START_PC = START_ADDR[PC_W-1:0];
  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                            state;
  logic [NUM_ENT-1:0][PC_W-1:0]      br_tbl;
  logic [PC_W-1:0]                   pc_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [PC_W-1:0]                   br_tgt;

  // Read sees the pre-edge array, so a same-cycle write to the branched
  // index only takes effect for later branches.
  assign br_tgt = br_tbl[br_idx_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      pc_q   <= '0;
      cnt_q  <= '0;
      br_tbl <= '0;
    end else begin
      if (lut_we_i) br_tbl[lut_addr_i] <= lut_data_i;
      case (state)
        IDLE, HALTED: begin
          if (start_i) begin
            state <= RUN;
            pc_q  <= START_PC;
            cnt_q <= '0;
          end
        end
        RUN: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
          // Halt leaves pc on the HALT instruction and beats a branch.
          if (halt_i)        state <= HALTED;
          else if (branch_i) pc_q  <= br_tgt;
          else               pc_q  <= pc_q + PC_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign cycle_cnt_o = cnt_q;
  assign run_o       = (state == RUN);
  assign done_o      = (state == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a default instance plus a CNT_W=4
// instance sharing the same stimulus to exercise counter saturation.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0, start_i = 1'b0, halt_i = 1'b0, branch_i = 1'b0;
  logic [3:0]  br_idx_i = '0, lut_addr_i = '0;
  logic        lut_we_i = 1'b0;
  logic [9:0]  lut_data_i = '0;
  logic [9:0]  pc_o, s_pc_o;
  logic        run_o, done_o, s_run_o, s_done_o;
  logic [15:0] cycle_cnt_o;
  logic [3:0]  s_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .halt_i(halt_i),
    .branch_i(branch_i), .br_idx_i(br_idx_i), .lut_we_i(lut_we_i),
    .lut_addr_i(lut_addr_i), .lut_data_i(lut_data_i), .pc_o(pc_o),
    .run_o(run_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o));

  pc_fetch_unit #(.PC_W(10), .START_ADDR(0), .CNT_W(4)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .halt_i(halt_i),
    .branch_i(branch_i), .br_idx_i(br_idx_i), .lut_we_i(lut_we_i),
    .lut_addr_i(lut_addr_i), .lut_data_i(lut_data_i), .pc_o(s_pc_o),
    .run_o(s_run_o), .done_o(s_done_o), .cycle_cnt_o(s_cnt_o));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    checks++; if (pc_o !== 10'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", pc_o); end
    checks++; if ({run_o, done_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {run_o, done_o}); end
    checks++; if (cycle_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt_o); end
    // Idle must ignore branch/halt.
    branch_i = 1'b1; halt_i = 1'b1; tick(); branch_i = 1'b0; halt_i = 1'b0;
    checks++; if ({pc_o, run_o, done_o} !== {10'h000, 2'b00}) begin errors++; $display("FAIL idle_ignore got=%h/%b%b exp=000/00", pc_o, run_o, done_o); end
  endtask

  task automatic test_sequential();
    start_i = 1'b1; tick(); start_i = 1'b0;
    checks++; if (pc_o !== 10'h000 || run_o !== 1'b1) begin errors++; $display("FAIL start got=%h/%b exp=000/1", pc_o, run_o); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (pc_o !== 10'(k)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", k, pc_o, 10'(k)); end
    end
    checks++; if (cycle_cnt_o !== 16'd5 || run_o !== 1'b1) begin errors++; $display("FAIL seq_cnt got=%0d/%b exp=5/1", cycle_cnt_o, run_o); end
  endtask

  task automatic test_branch();
    lut_we_i = 1'b1; lut_addr_i = 4'd3; lut_data_i = 10'h1A0; tick(); lut_we_i = 1'b0;
    tick();
    checks++; if (pc_o !== 10'h007) begin errors++; $display("FAIL pre_branch got=%h exp=007", pc_o); end
    branch_i = 1'b1; br_idx_i = 4'd3; tick(); branch_i = 1'b0;
    checks++; if (pc_o !== 10'h1A0) begin errors++; $display("FAIL branch_tgt got=%h exp=1A0", pc_o); end
    tick();
    checks++; if (pc_o !== 10'h1A1) begin errors++; $display("FAIL branch_next got=%h exp=1A1", pc_o); end
  endtask

  task automatic test_read_before_write();
    lut_we_i = 1'b1; lut_addr_i = 4'd2; lut_data_i = 10'h010; tick();
    lut_data_i = 10'h050; branch_i = 1'b1; br_idx_i = 4'd2; tick();
    lut_we_i = 1'b0; branch_i = 1'b0;
    checks++; if (pc_o !== 10'h010) begin errors++; $display("FAIL rbw_old got=%h exp=010", pc_o); end
    tick();
    checks++; if (pc_o !== 10'h011) begin errors++; $display("FAIL rbw_inc got=%h exp=011", pc_o); end
    branch_i = 1'b1; tick(); branch_i = 1'b0;
    checks++; if (pc_o !== 10'h050) begin errors++; $display("FAIL rbw_new got=%h exp=050", pc_o); end
  endtask

  task automatic test_halt();
    lut_we_i = 1'b1; lut_addr_i = 4'd4; lut_data_i = 10'h00C; tick(); lut_we_i = 1'b0;
    branch_i = 1'b1; br_idx_i = 4'd4; tick();
    checks++; if (pc_o !== 10'h00C) begin errors++; $display("FAIL halt_setup got=%h exp=00C", pc_o); end
    halt_i = 1'b1; br_idx_i = 4'd3; tick(); halt_i = 1'b0;
    checks++; if ({pc_o, run_o, done_o} !== {10'h00C, 2'b01}) begin errors++; $display("FAIL halt_state got=%h/%b%b exp=00C/01", pc_o, run_o, done_o); end
    // 16 RUN edges since start, including the halting edge.
    checks++; if (cycle_cnt_o !== 16'd16) begin errors++; $display("FAIL halt_cnt got=%0d exp=16", cycle_cnt_o); end
    tick(); branch_i = 1'b0; halt_i = 1'b1; tick(); halt_i = 1'b0;
    checks++; if ({pc_o, done_o, cycle_cnt_o} !== {10'h00C, 1'b1, 16'd16}) begin errors++; $display("FAIL halted_hold got=%h/%b/%0d exp=00C/1/16", pc_o, done_o, cycle_cnt_o); end
    start_i = 1'b1; tick();
    checks++; if ({pc_o, run_o, done_o, cycle_cnt_o} !== {10'h000, 2'b10, 16'd0}) begin errors++; $display("FAIL restart got=%h/%b%b/%0d exp=000/10/0", pc_o, run_o, done_o, cycle_cnt_o); end
    tick(); start_i = 1'b0;
    checks++; if (pc_o !== 10'h001) begin errors++; $display("FAIL start_in_run got=%h exp=001", pc_o); end
  endtask

  task automatic test_wrap();
    lut_we_i = 1'b1; lut_addr_i = 4'd5; lut_data_i = 10'h3FF; tick(); lut_we_i = 1'b0;
    branch_i = 1'b1; br_idx_i = 4'd5; tick(); branch_i = 1'b0;
    checks++; if (pc_o !== 10'h3FF) begin errors++; $display("FAIL wrap_setup got=%h exp=3FF", pc_o); end
    tick();
    checks++; if (pc_o !== 10'h000) begin errors++; $display("FAIL wrap got=%h exp=000", pc_o); end
  endtask

  task automatic test_reset_mid();
    lut_we_i = 1'b1; lut_addr_i = 4'd6; lut_data_i = 10'h021; tick(); lut_we_i = 1'b0;
    branch_i = 1'b1; br_idx_i = 4'd6; tick(); branch_i = 1'b0;
    checks++; if (pc_o !== 10'h021) begin errors++; $display("FAIL rst_setup got=%h exp=021", pc_o); end
    reset_i = 1'b1; lut_we_i = 1'b1; lut_addr_i = 4'd7; lut_data_i = 10'h123; tick();
    reset_i = 1'b0; lut_we_i = 1'b0;
    checks++; if ({pc_o, run_o, done_o, cycle_cnt_o} !== {10'h000, 2'b00, 16'd0}) begin errors++; $display("FAIL rst_mid got=%h/%b%b/%0d exp=000/00/0", pc_o, run_o, done_o, cycle_cnt_o); end
    tick(); tick();
    checks++; if ({pc_o, run_o} !== {10'h000, 1'b0}) begin errors++; $display("FAIL rst_needs_start got=%h/%b exp=000/0", pc_o, run_o); end
    start_i = 1'b1; tick(); start_i = 1'b0;
    branch_i = 1'b1; br_idx_i = 4'd3; tick(); branch_i = 1'b0;
    checks++; if (pc_o !== 10'h000) begin errors++; $display("FAIL rst_tbl3 got=%h exp=000", pc_o); end
    tick();
    branch_i = 1'b1; br_idx_i = 4'd7; tick(); branch_i = 1'b0;
    checks++; if (pc_o !== 10'h000) begin errors++; $display("FAIL rst_tbl7 got=%h exp=000", pc_o); end
  endtask

  task automatic test_saturate();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) begin
        checks++; if (s_cnt_o !== 4'd14) begin errors++; $display("FAIL sat_pre got=%0d exp=14", s_cnt_o); end
      end
    end
    checks++; if (s_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_cnt got=%0d exp=15", s_cnt_o); end
    checks++; if (cycle_cnt_o !== 16'd20 || s_pc_o !== 10'd20) begin errors++; $display("FAIL sat_wide got=%0d/%h exp=20/014", cycle_cnt_o, s_pc_o); end
  endtask

  initial begin
    tick();
    test_reset();
    test_sequential();
    test_branch();
    test_read_before_write();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
